// File: rtl/uart_wb_seq_ctrl.sv
// uart_wb_seq_ctrl
//   Wishbone master sequencer that owns the slave port of a 16550-style UART.
//   On cfg_start it programs DLL/DLM (with DLAB set), LCR, FCR and IER, then
//   drains a valid/ready byte stream into THR. Before every THR write it polls
//   LSR and only writes once THRE (bit 5) is set.
//
// Ports
//   wb_clk_i, wb_rst_ni   clock (rising edge), asynchronous active-low reset
//   cfg_start, divisor    config request pulse and baud divisor (sampled with it)
//   tx_valid/tx_data/tx_ready  byte input stream; accepted only in READY
//   cfg_done, busy, err   status: config complete, sequencer active, ack timeout
//   wbm_*                 Wishbone master (5-bit byte address, 32-bit data)
//
// Optional feature
//   WB_ACK_TIMEOUT_EN: when defined, a transaction that sees no ack for
//   ACK_TIMEOUT cycles is aborted, err is set and the sequencer returns to IDLE.
//   When undefined, the sequencer waits for ack forever and err is tied low.

module uart_wb_seq_ctrl #(
    parameter logic [7:0] LCR_VAL     = 8'h03,
    parameter logic [7:0] FCR_VAL     = 8'h07,
    parameter logic [7:0] IER_VAL     = 8'h00,
    parameter int         POLL_GAP    = 4,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cfg_start,
    input  logic [15:0] divisor,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        cfg_done,
    output logic        busy,
    output logic        err,
    output logic [4:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i
);

    localparam int GW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_READY,
        S_POLL,
        S_PGAP,
        S_WRTHR
    } state_t;

    state_t        state_q;
    logic [2:0]    cfg_idx_q;
    logic [15:0]   div_q;
    logic [7:0]    byte_q;
    logic [GW-1:0] gap_q;
    logic          bus_q;
    logic          we_q;
    logic [2:0]    adr_q;
    logic [3:0]    sel_q;
    logic [7:0]    dat_q;
    logic          cfg_done_q;

    // Parameters of the transaction the current state would launch next.
    logic [2:0]    adr_d;
    logic [7:0]    dat_d;
    logic          we_d;

    logic          start_ok;
    logic          abort;
    logic [7:0]    rd_byte;

    // Config write table: {address, data} for each of the six steps.
    function automatic logic [10:0] cfg_entry(input logic [2:0] idx, input logic [15:0] div);
        case (idx)
            3'd0:    cfg_entry = {3'd3, LCR_VAL | 8'h80};
            3'd1:    cfg_entry = {3'd0, div[7:0]};
            3'd2:    cfg_entry = {3'd1, div[15:8]};
            3'd3:    cfg_entry = {3'd3, LCR_VAL};
            3'd4:    cfg_entry = {3'd2, FCR_VAL};
            default: cfg_entry = {3'd1, IER_VAL};
        endcase
    endfunction

    assign start_ok = cfg_start && (state_q == S_IDLE || state_q == S_READY);

    // The UART answers a byte register on the lane selected by the low address bits.
    assign rd_byte = wbm_dat_i[{adr_q[1:0], 3'b000} +: 8];

    always_comb begin
        adr_d = 3'd0;
        dat_d = 8'h00;
        we_d  = 1'b0;
        case (state_q)
            S_CFG: begin
                {adr_d, dat_d} = cfg_entry(cfg_idx_q, div_q);
                we_d           = 1'b1;
            end
            S_POLL, S_PGAP: begin
                adr_d = 3'd5;
            end
            S_WRTHR: begin
                adr_d = 3'd0;
                dat_d = byte_q;
                we_d  = 1'b1;
            end
            default: begin
                adr_d = 3'd0;
            end
        endcase
    end

`ifdef WB_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q;
    logic          err_q;

    // Abort on the edge that would complete the ACK_TIMEOUT-th unacknowledged cycle.
    assign abort = bus_q && !wbm_ack_i && (to_cnt_q == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (bus_q && !wbm_ack_i && !abort) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
            if (abort) begin
                err_q <= 1'b1;
            end else if (start_ok) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            cfg_idx_q  <= 3'd0;
            div_q      <= 16'h0000;
            byte_q     <= 8'h00;
            gap_q      <= '0;
            bus_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 3'd0;
            sel_q      <= 4'b0000;
            dat_q      <= 8'h00;
            cfg_done_q <= 1'b0;
        end else if (abort) begin
            state_q    <= S_IDLE;
            bus_q      <= 1'b0;
            we_q       <= 1'b0;
            byte_q     <= 8'h00;
            cfg_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_q    <= S_CFG;
                        cfg_idx_q  <= 3'd0;
                        div_q      <= divisor;
                        cfg_done_q <= 1'b0;
                    end
                end

                S_CFG: begin
                    if (!bus_q) begin
                        bus_q <= 1'b1;
                        we_q  <= we_d;
                        adr_q <= adr_d;
                        sel_q <= 4'b0001 << adr_d[1:0];
                        dat_q <= dat_d;
                    end else if (wbm_ack_i) begin
                        bus_q <= 1'b0;
                        if (cfg_idx_q == 3'd5) begin
                            cfg_done_q <= 1'b1;
                            state_q    <= S_READY;
                        end else begin
                            cfg_idx_q <= cfg_idx_q + 3'd1;
                        end
                    end
                end

                S_READY: begin
                    // A new config request takes priority over a waiting byte.
                    if (cfg_start) begin
                        state_q    <= S_CFG;
                        cfg_idx_q  <= 3'd0;
                        div_q      <= divisor;
                        cfg_done_q <= 1'b0;
                    end else if (tx_valid) begin
                        byte_q  <= tx_data;
                        state_q <= S_POLL;
                    end
                end

                S_POLL: begin
                    if (!bus_q) begin
                        bus_q <= 1'b1;
                        we_q  <= we_d;
                        adr_q <= adr_d;
                        sel_q <= 4'b0001 << adr_d[1:0];
                        dat_q <= dat_d;
                    end else if (wbm_ack_i) begin
                        bus_q <= 1'b0;
                        if (rd_byte[5]) begin
                            state_q <= S_WRTHR;
                        end else begin
                            state_q <= S_PGAP;
                            gap_q   <= GW'(POLL_GAP - 1);
                        end
                    end
                end

                S_PGAP: begin
                    // The re-poll is launched from here so exactly POLL_GAP idle
                    // cycles separate the two LSR reads.
                    if (gap_q == '0) begin
                        state_q <= S_POLL;
                        bus_q   <= 1'b1;
                        we_q    <= we_d;
                        adr_q   <= adr_d;
                        sel_q   <= 4'b0001 << adr_d[1:0];
                        dat_q   <= dat_d;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end

                S_WRTHR: begin
                    if (!bus_q) begin
                        bus_q <= 1'b1;
                        we_q  <= we_d;
                        adr_q <= adr_d;
                        sel_q <= 4'b0001 << adr_d[1:0];
                        dat_q <= dat_d;
                    end else if (wbm_ack_i) begin
                        bus_q   <= 1'b0;
                        state_q <= S_READY;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    bus_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready  = (state_q == S_READY);
    assign busy      = (state_q != S_IDLE) && (state_q != S_READY);
    assign cfg_done  = cfg_done_q;
    assign wbm_cyc_o = bus_q;
    assign wbm_stb_o = bus_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = {2'b00, adr_q};
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = {4{dat_q}};

endmodule
